// File: rtl/axis_width_packer_if.sv
// AXI-Stream bus bundle shared by the narrow and wide sides of axis_width_packer.
// AXIS_WIDTH_PACKER_TUSER_EN adds a 1-bit tuser sideband to the bundle.
`timescale 1ns/1ps

interface axis_width_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
`ifdef AXIS_WIDTH_PACKER_TUSER_EN
    logic                  tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
`else
    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
`endif
endinterface

// File: rtl/axis_width_packer.sv
// Single-clock AXI-Stream upsizer: packs narrow beats little-endian into wide words with tkeep.
// Optional bad-frame flag passthrough (OR of beat tuser) when AXIS_WIDTH_PACKER_TUSER_EN is defined.
`timescale 1ns/1ps

module axis_width_packer #(
    parameter int S_DATA_WIDTH    = 8,
    parameter int M_DATA_WIDTH    = 32,
    parameter int M_KEEP_WIDTH    = M_DATA_WIDTH / 8,
    parameter int SEG_COUNT       = M_DATA_WIDTH / S_DATA_WIDTH,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axis_width_packer_if.slave         s_axis,
    axis_width_packer_if.master        m_axis,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam int S_KEEP_WIDTH = S_DATA_WIDTH / 8;
    localparam int SEG_W        = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_COUNT - 1);

    typedef struct packed {
        logic [M_DATA_WIDTH-1:0] data;
        logic [M_KEEP_WIDTH-1:0] keep;
        logic                    last;
`ifdef AXIS_WIDTH_PACKER_TUSER_EN
        logic                    user;
`endif
    } word_t;

    logic [SEG_W-1:0]           seg_cnt_q, seg_cnt_d;
    word_t                      acc_q, acc_d;
    logic                       acc_done_q, acc_done_d;
    logic                       s_ready_q, s_ready_d;
    word_t                      out_q, out_d;
    logic                       out_valid_q, out_valid_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

    word_t beat_word;
    logic  s_fire;
    logic  m_fire;
    logic  out_free;
    logic  word_end;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        s_fire   = s_axis.tvalid & s_ready_q;
        m_fire   = out_valid_q & m_axis.tready;
        out_free = ~out_valid_q | m_fire;
        word_end = (seg_cnt_q == SEG_LAST) | s_axis.tlast;

        // Accumulator word with the current beat merged into its lane; untouched lanes stay 0.
        beat_word = acc_q;
        beat_word.data[seg_cnt_q * S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis.tdata;
        beat_word.keep[seg_cnt_q * S_KEEP_WIDTH +: S_KEEP_WIDTH] = '1;
        beat_word.last = s_axis.tlast;
`ifdef AXIS_WIDTH_PACKER_TUSER_EN
        beat_word.user = acc_q.user | s_axis.tuser;
`endif

        seg_cnt_d   = seg_cnt_q;
        acc_d       = acc_q;
        acc_done_d  = acc_done_q;
        out_d       = out_q;
        out_valid_d = out_valid_q & ~m_fire;
        frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(m_fire & out_q.last);

        if (acc_done_q) begin
            // A finished word is parked; hand it over as soon as the output slot frees.
            if (out_free) begin
                out_d       = acc_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
                seg_cnt_d   = '0;
                acc_done_d  = 1'b0;
            end
        end else if (s_fire) begin
            if (word_end) begin
                seg_cnt_d = '0;
                if (out_free) begin
                    out_d       = beat_word;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d      = beat_word;
                    acc_done_d = 1'b1;
                end
            end else begin
                acc_d     = beat_word;
                seg_cnt_d = seg_cnt_q + SEG_W'(1);
            end
        end

        s_ready_d = ~acc_done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset as well, because every output must read 0 while rst_n is low.
            seg_cnt_q   <= '0;
            acc_q       <= '0;
            acc_done_q  <= 1'b0;
            s_ready_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge state.
            seg_cnt_q   <= seg_cnt_d;
            acc_q       <= acc_d;
            acc_done_q  <= acc_done_d;
            s_ready_q   <= s_ready_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tkeep  = out_q.keep;
    assign m_axis.tlast  = out_q.last;
    assign m_axis.tvalid = out_valid_q;
`ifdef AXIS_WIDTH_PACKER_TUSER_EN
    assign m_axis.tuser  = out_q.user;
`endif
    assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_axis_width_packer.sv
// Directed self-checking bench for axis_width_packer (8-bit to 32-bit, default build).
`timescale 1ns/1ps

module tb_axis_width_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] frame_count;

    int    tests_run = 0;
    int    tests_failed = 0;
    word_t mon_q[$];
    bit    mon_en = 1'b1;

    axis_width_packer_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1)) s_axis ();
    axis_width_packer_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) m_axis ();

    axis_width_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axis      (s_axis),
        .m_axis      (m_axis),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Record every master-side transfer.
    always @(posedge clk) begin
        if (mon_en && rst_n && m_axis.tvalid && m_axis.tready)
            mon_q.push_back({m_axis.tdata, m_axis.tkeep, m_axis.tlast});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [7:0] d, input logic l, output int stalls);
        stalls = 0;
        @(negedge clk);
        s_axis.tdata  = d;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        while (!s_axis.tready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int c = 0;
        while (mon_q.size() < n && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        logic [54:0] outs;
        #12;
        outs = {s_axis.tready, m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata, frame_count};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (s_axis.tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_before_edge: got %b expected 0", s_axis.tready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (s_axis.tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_after_edge: got %b expected 1", s_axis.tready);
        end
    endtask

    task automatic test_full_rate();
        int    st, total;
        word_t w;
        total = 0;
        mon_q.delete();
        m_axis.tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_beat(8'(i), 1'b0, st);
            total += st;
        end
        idle();
        wait_words(2);
        tests_run++;
        if (total !== 0) begin
            tests_failed++;
            $display("FAIL full_rate_stalls: got %0d expected 0", total);
        end
        w = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
        tests_run++;
        if (w !== {32'h04030201, 4'hF, 1'b0}) begin
            tests_failed++;
            $display("FAIL full_rate_w0: got %h expected %h", w, {32'h04030201, 4'hF, 1'b0});
        end
        w = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
        tests_run++;
        if (w !== {32'h08070605, 4'hF, 1'b0}) begin
            tests_failed++;
            $display("FAIL full_rate_w1: got %h expected %h", w, {32'h08070605, 4'hF, 1'b0});
        end
        tests_run++;
        if (frame_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL full_rate_count: got %0d expected 0", frame_count);
        end
    endtask

    task automatic test_partial_frame();
        int    st;
        word_t w;
        mon_q.delete();
        tests_run++;
        if (frame_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL partial_count_before: got %0d expected 0", frame_count);
        end
        send_beat(8'hAA, 1'b0, st);
        send_beat(8'hBB, 1'b0, st);
        send_beat(8'hCC, 1'b1, st);
        idle();
        wait_words(1);
        w = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
        tests_run++;
        if (w !== {32'h00CCBBAA, 4'h7, 1'b1}) begin
            tests_failed++;
            $display("FAIL partial_word: got %h expected %h", w, {32'h00CCBBAA, 4'h7, 1'b1});
        end
        tests_run++;
        if (frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL partial_count_after: got %0d expected 1", frame_count);
        end
    endtask

    task automatic test_single_byte();
        int    st;
        word_t w;
        mon_q.delete();
        send_beat(8'h5A, 1'b1, st);
        idle();
        wait_words(1);
        w = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
        tests_run++;
        if (w !== {32'h0000005A, 4'h1, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_word: got %h expected %h", w, {32'h0000005A, 4'h1, 1'b1});
        end
        send_beat(8'h11, 1'b0, st);
        send_beat(8'h22, 1'b1, st);
        idle();
        wait_words(1);
        w = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
        tests_run++;
        if (w !== {32'h00002211, 4'h3, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_next_lane0: got %h expected %h", w, {32'h00002211, 4'h3, 1'b1});
        end
        tests_run++;
        if (frame_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL single_count: got %0d expected 3", frame_count);
        end
    endtask

    task automatic test_backpressure();
        int    idx;
        bit    acc;
        word_t w;
        word_t exp_w[3];
        exp_w[0] = {32'h13121110, 4'hF, 1'b0};
        exp_w[1] = {32'h17161514, 4'hF, 1'b0};
        exp_w[2] = {32'h1B1A1918, 4'hF, 1'b0};
        mon_q.delete();
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            m_axis.tready = 1'b0;
            s_axis.tvalid = (idx < 12);
            s_axis.tdata  = 8'(8'h10 + idx);
            s_axis.tlast  = 1'b0;
            acc = s_axis.tvalid && s_axis.tready;
            if (c == 10) begin
                tests_run++;
                if (m_axis.tdata !== 32'h13121110) begin
                    tests_failed++;
                    $display("FAIL bp_hold_mid: got %h expected 13121110", m_axis.tdata);
                end
            end
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        tests_run++;
        if (idx !== 8) begin
            tests_failed++;
            $display("FAIL bp_accepted: got %0d expected 8", idx);
        end
        tests_run++;
        if ({s_axis.tready, m_axis.tvalid} !== 2'b01) begin
            tests_failed++;
            $display("FAIL bp_flags: got ready=%b valid=%b expected ready=0 valid=1", s_axis.tready, m_axis.tvalid);
        end
        tests_run++;
        if (m_axis.tdata !== 32'h13121110 || mon_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL bp_hold_end: got %h (%0d sent) expected 13121110 (0 sent)", m_axis.tdata, mon_q.size());
        end
        for (int c = 0; c < 40 && idx < 12; c++) begin
            m_axis.tready = 1'b1;
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = 8'(8'h10 + idx);
            acc = s_axis.tready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
        end
        s_axis.tvalid = 1'b0;
        wait_words(3);
        repeat (4) @(negedge clk);
        tests_run++;
        if (idx !== 12 || mon_q.size() !== 3) begin
            tests_failed++;
            $display("FAIL bp_drain_count: got %0d accepted %0d words expected 12 accepted 3 words", idx, mon_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            w = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
            tests_run++;
            if (w !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got %h expected %h", i, w, exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int          st, total;
        word_t       w;
        logic [54:0] outs;
        total = 0;
        mon_q.delete();
        m_axis.tready = 1'b1;
        send_beat(8'hE1, 1'b0, st);
        send_beat(8'hE2, 1'b0, st);
        idle();
        rst_n = 1'b0;
        #2;
        outs = {s_axis.tready, m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata, frame_count};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send_beat(8'(8'h30 + i), 1'b0, st);
            total += st;
        end
        idle();
        wait_words(1);
        repeat (3) @(negedge clk);
        tests_run++;
        if (mon_q.size() !== 1 || total !== 0) begin
            tests_failed++;
            $display("FAIL midrst_count: got %0d words %0d stalls expected 1 word 0 stalls", mon_q.size(), total);
        end
        w = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
        tests_run++;
        if (w !== {32'h34333231, 4'hF, 1'b0}) begin
            tests_failed++;
            $display("FAIL midrst_word: got %h expected %h", w, {32'h34333231, 4'hF, 1'b0});
        end
    endtask

    task automatic test_counter_wrap();
        int    acc_cnt, cyc, st;
        word_t w;
        mon_en = 1'b0;
        acc_cnt = 0;
        cyc = 0;
        @(negedge clk);
        m_axis.tready = 1'b1;
        s_axis.tdata  = 8'h77;
        s_axis.tlast  = 1'b1;
        s_axis.tvalid = 1'b1;
        while (acc_cnt < 65535 && cyc < 70000) begin
            if (s_axis.tready) acc_cnt++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (acc_cnt !== 65535 || frame_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preload: got %0d frames count %h expected 65535 frames count FFFF", acc_cnt, frame_count);
        end
        mon_en = 1'b1;
        mon_q.delete();
        send_beat(8'h42, 1'b1, st);
        idle();
        wait_words(1);
        tests_run++;
        if (frame_count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap_count: got %h expected 0000", frame_count);
        end
        w = (mon_q.size() > 0) ? mon_q.pop_front() : '1;
        tests_run++;
        if (w !== {32'h00000042, 4'h1, 1'b1}) begin
            tests_failed++;
            $display("FAIL wrap_word: got %h expected %h", w, {32'h00000042, 4'h1, 1'b1});
        end
    endtask

    initial begin
        s_axis.tdata  = '0;
        s_axis.tkeep  = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
`ifdef AXIS_WIDTH_PACKER_TUSER_EN
        s_axis.tuser  = 1'b0;
`endif
        m_axis.tready = 1'b0;

        test_reset();
        test_full_rate();
        test_partial_frame();
        test_single_byte();
        test_backpressure();
        test_reset_mid_word();
        test_counter_wrap();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
